// File: rtl/toy_bus_ack_dec_node_if.sv
`default_nettype none
// ==========================================================================
// toy_bus_ack_dec_node_if : one ToyBusAck channel (valid/ready + payload)
// Rev 1.0
// ==========================================================================
interface toy_bus_ack_dec_node_if #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic              vld;
  logic              rdy;
  logic              opcode;
  logic [DATA_W-1:0] data;
  logic [ID_W-1:0]   src_id;
  logic [ID_W-1:0]   tgt_id;

  modport master (
    output vld,
    output opcode,
    output data,
    output src_id,
    output tgt_id,
    input  rdy
  );

  modport slave (
    input  vld,
    input  opcode,
    input  data,
    input  src_id,
    input  tgt_id,
    output rdy
  );
endinterface
`default_nettype wire

// File: rtl/toy_bus_ack_dec_node.sv
`default_nettype none
// ==========================================================================
// toy_bus_ack_dec_node : 1:4 ToyBusAck split by tgt_id, 2-entry FIFO per port
// Optional illegal-target check: TOY_BUS_DEC_ERR_CHK_EN.  Rev 1.0
// ==========================================================================
module toy_bus_ack_dec_node #(
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int SEL_LSB   = 0,
  parameter int NODE_BASE = 0
) (
  input  wire                       clk,
  input  wire                       rst_n,
  toy_bus_ack_dec_node_if.slave     in0,
  toy_bus_ack_dec_node_if.master    out0,
  toy_bus_ack_dec_node_if.master    out1,
  toy_bus_ack_dec_node_if.master    out2,
  toy_bus_ack_dec_node_if.master    out3,
  output logic                      err_vld,
  output logic [7:0]                err_cnt
);
  localparam int NP = 4;
  localparam int PW = 1 + DATA_W + 2 * ID_W;

  typedef logic [PW-1:0] beat_t;

  logic [1:0]    sel;
  logic [NP-1:0] dec;
  logic [NP-1:0] full;
  logic [NP-1:0] push;
  logic [NP-1:0] pop;
  logic [NP-1:0] out_vld;
  logic [NP-1:0] out_rdy;
  beat_t         in_beat;
  beat_t         head [NP];

  assign sel     = in0.tgt_id[SEL_LSB +: 2];
  assign dec     = NP'(1) << sel;
  assign in_beat = {in0.opcode, in0.data, in0.src_id, in0.tgt_id};

`ifdef TOY_BUS_DEC_ERR_CHK_EN
  logic illegal;

  assign illegal = (in0.tgt_id[ID_W-1:2] != (ID_W-2)'(NODE_BASE));
  // Illegal beats are swallowed without regard to FIFO occupancy
  assign in0.rdy = illegal | ~full[sel];
  assign push    = illegal ? '0 : (dec & {NP{in0.vld & ~full[sel]}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_vld <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      err_vld <= in0.vld & illegal;
      if (in0.vld && illegal && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end
`else
  // Ready looks only at occupancy, never at downstream ready
  assign in0.rdy = ~full[sel];
  assign push    = dec & {NP{in0.vld & ~full[sel]}};
  assign err_vld = 1'b0;
  assign err_cnt = 8'd0;
`endif

  for (genvar n = 0; n < NP; n++) begin : g_port
    beat_t      mem [2];
    logic [1:0] cnt;
    logic       wptr;
    logic       rptr;

    assign full[n]    = (cnt == 2'd2);
    assign out_vld[n] = (cnt != 2'd0);
    assign pop[n]     = out_vld[n] & out_rdy[n];
    assign head[n]    = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt    <= 2'd0;
        wptr   <= 1'b0;
        rptr   <= 1'b0;
        mem[0] <= '0;
        mem[1] <= '0;
      end else begin
        if (push[n]) begin
          mem[wptr] <= in_beat;
          wptr      <= ~wptr;
        end
        if (pop[n]) begin
          rptr <= ~rptr;
        end
        case ({push[n], pop[n]})
          2'b10:   cnt <= cnt + 2'd1;
          2'b01:   cnt <= cnt - 2'd1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

  assign out0.vld = out_vld[0];
  assign out1.vld = out_vld[1];
  assign out2.vld = out_vld[2];
  assign out3.vld = out_vld[3];

  assign {out0.opcode, out0.data, out0.src_id, out0.tgt_id} = head[0];
  assign {out1.opcode, out1.data, out1.src_id, out1.tgt_id} = head[1];
  assign {out2.opcode, out2.data, out2.src_id, out2.tgt_id} = head[2];
  assign {out3.opcode, out3.data, out3.src_id, out3.tgt_id} = head[3];

  assign out_rdy = {out3.rdy, out2.rdy, out1.rdy, out0.rdy};

endmodule
`default_nettype wire

// File: tb/tb_toy_bus_ack_dec_node.sv
`default_nettype none
// ==========================================================================
// tb_toy_bus_ack_dec_node : scoreboard bench for the 1:4 ack decode node
// Rev 1.0
// ==========================================================================
`timescale 1ns/1ps
module tb_toy_bus_ack_dec_node;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int PW     = 1 + DATA_W + 2 * ID_W;

  typedef logic [PW-1:0] beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       err_vld;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  toy_bus_ack_dec_node_if #(.DATA_W(DATA_W), .ID_W(ID_W)) in0 ();
  toy_bus_ack_dec_node_if #(.DATA_W(DATA_W), .ID_W(ID_W)) out0 ();
  toy_bus_ack_dec_node_if #(.DATA_W(DATA_W), .ID_W(ID_W)) out1 ();
  toy_bus_ack_dec_node_if #(.DATA_W(DATA_W), .ID_W(ID_W)) out2 ();
  toy_bus_ack_dec_node_if #(.DATA_W(DATA_W), .ID_W(ID_W)) out3 ();

  toy_bus_ack_dec_node dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in0     (in0),
    .out0    (out0),
    .out1    (out1),
    .out2    (out2),
    .out3    (out3),
    .err_vld (err_vld),
    .err_cnt (err_cnt)
  );

  logic [3:0] o_vld;
  logic [3:0] o_rdy;
  beat_t      o_beat [4];

  assign o_vld     = {out3.vld, out2.vld, out1.vld, out0.vld};
  assign o_rdy     = {out3.rdy, out2.rdy, out1.rdy, out0.rdy};
  assign o_beat[0] = {out0.opcode, out0.data, out0.src_id, out0.tgt_id};
  assign o_beat[1] = {out1.opcode, out1.data, out1.src_id, out1.tgt_id};
  assign o_beat[2] = {out2.opcode, out2.data, out2.src_id, out2.tgt_id};
  assign o_beat[3] = {out3.opcode, out3.data, out3.src_id, out3.tgt_id};

  int    tests = 0;
  int    fails = 0;
  beat_t exp_q [4][$];

  function automatic bit is_legal(input logic [3:0] tgt);
`ifdef TOY_BUS_DEC_ERR_CHK_EN
    return (tgt[3:2] == 2'b00);
`else
    return 1'b1;
`endif
  endfunction

  function automatic beat_t cur_beat();
    return {in0.opcode, in0.data, in0.src_id, in0.tgt_id};
  endfunction

  // Pop side of the scoreboard: every output handshake must match the model head
  always @(negedge clk) begin
    beat_t e;
    if (rst_n) begin
      for (int p = 0; p < 4; p++) begin
        if (o_vld[p] && o_rdy[p]) begin
          tests++;
          if (exp_q[p].size() == 0) begin
            fails++;
            $display("FAIL pop_port%0d: got beat %h, expected no beat", p, o_beat[p]);
          end else begin
            e = exp_q[p].pop_front();
            if (o_beat[p] !== e) begin
              fails++;
              $display("FAIL pop_port%0d: got beat %h, expected %h", p, o_beat[p], e);
            end
          end
        end
      end
    end
  end

  task automatic set_rdy(input logic [3:0] r);
    out0.rdy = r[0];
    out1.rdy = r[1];
    out2.rdy = r[2];
    out3.rdy = r[3];
  endtask

  task automatic drive(input logic [3:0] tgt, input logic [31:0] d);
    in0.vld    = 1'b1;
    in0.tgt_id = tgt;
    in0.data   = d;
    in0.opcode = d[0];
    in0.src_id = ~tgt;
  endtask

  // Waits for acceptance, records the expected beat, returns at posedge+1
  task automatic wait_acc(output int waited);
    bit done;
    waited = 0;
    done   = 1'b0;
    while (!done && waited < 64) begin
      @(negedge clk);
      if (in0.rdy) done = 1'b1;
      else         waited++;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in0_rdy=0 for %0d cycles, required 1", waited);
    end else if (is_legal(in0.tgt_id)) begin
      exp_q[in0.tgt_id[1:0]].push_back(cur_beat());
    end
    @(posedge clk);
    #1;
    in0.vld = 1'b0;
  endtask

  task automatic send(input logic [3:0] tgt, input logic [31:0] d, output int waited);
    drive(tgt, d);
    wait_acc(waited);
  endtask

  task automatic drain(input string name);
    int left;
    left = 1;
    for (int i = 0; i < 40 && left != 0; i++) begin
      @(negedge clk);
      left = exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size();
    end
    @(negedge clk);
    tests++;
    if (left != 0 || o_vld !== 4'b0000) begin
      fails++;
      $display("FAIL %s_drain: %0d beats undelivered, out_vld=%b, required 0 and 0000",
               name, left, o_vld);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in0.vld = 1'b0; in0.opcode = 1'b0; in0.data = '0; in0.src_id = '0; in0.tgt_id = '0;
    set_rdy(4'hF);
    rst_n = 1'b0;
    #12;
    tests++;
    if (o_vld !== 4'b0000) begin
      fails++; $display("FAIL reset_vld: got %b, required 0000", o_vld);
    end
    tests++;
    if (in0.rdy !== 1'b1) begin
      fails++; $display("FAIL reset_in_rdy: got %b, required 1", in0.rdy);
    end
    for (int p = 0; p < 4; p++) begin
      tests++;
      if (o_beat[p] !== '0) begin
        fails++; $display("FAIL reset_payload%0d: got %h, required 0", p, o_beat[p]);
      end
    end
    tests++;
    if (err_vld !== 1'b0 || err_cnt !== 8'd0) begin
      fails++; $display("FAIL reset_err: got vld=%b cnt=%0d, required 0 0", err_vld, err_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int w;
    beat_t e;
    set_rdy(4'hF);
    send(4'h2, 32'hA5A5_0001, w);
    e = {1'b1, 32'hA5A5_0001, 4'hD, 4'h2};
    tests++;
    if (w != 0) begin
      fails++; $display("FAIL single_accept: stalled %0d cycles, required 0", w);
    end
    tests++;
    if (o_vld !== 4'b0100) begin
      fails++; $display("FAIL single_vld: got %b, required 0100", o_vld);
    end
    tests++;
    if (o_beat[2] !== e) begin
      fails++; $display("FAIL single_payload: got %h, required %h", o_beat[2], e);
    end
    drain("single");
  endtask

  task automatic test_back_to_back();
    int w;
    int stalls;
    stalls = 0;
    set_rdy(4'hF);
    for (int i = 0; i < 16; i++) begin
      send(4'(i % 4), $urandom, w);
      stalls += w;
    end
    tests++;
    if (stalls != 0) begin
      fails++; $display("FAIL b2b_rdy: %0d stall cycles, required 0", stalls);
    end
    drain("b2b");
  endtask

  task automatic test_hol();
    int w;
    set_rdy(4'b1101);
    send(4'h1, 32'h1111_0001, w);
    send(4'h1, 32'h1111_0002, w);
    drive(4'h1, 32'h1111_0003);
    @(negedge clk);
    tests++;
    if (in0.rdy !== 1'b0) begin
      fails++; $display("FAIL hol_full_rdy: got %b, required 0", in0.rdy);
    end
    @(posedge clk);
    #1;
    set_rdy(4'hF);
    @(negedge clk);
    tests++;
    if (in0.rdy !== 1'b0) begin
      fails++; $display("FAIL hol_pop_cycle_rdy: got %b, required 0", in0.rdy);
    end
    wait_acc(w);
    tests++;
    if (w != 0) begin
      fails++; $display("FAIL hol_third_accept: stalled %0d cycles after pop, required 0", w);
    end
    drain("hol");
  endtask

  task automatic test_other_port();
    int w;
    beat_t snap;
    bit bad;
    set_rdy(4'b0111);
    send(4'h3, 32'h3333_0001, w);
    send(4'h3, 32'h3333_0002, w);
    snap = {1'b1, 32'h3333_0001, 4'hC, 4'h3};
    send(4'h0, 32'h0000_00AA, w);
    tests++;
    if (w != 0) begin
      fails++; $display("FAIL other_accept: stalled %0d cycles, required 0", w);
    end
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (o_beat[3] !== snap || o_vld[3] !== 1'b1) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++; $display("FAIL other_stable: out3 beat %h vld %b, required %h 1", o_beat[3], o_vld[3], snap);
    end
    tests++;
    if (exp_q[0].size() != 0) begin
      fails++; $display("FAIL other_drain0: %0d beats left on port 0, required 0", exp_q[0].size());
    end
    @(posedge clk);
    #1;
    set_rdy(4'hF);
    drain("other");
  endtask

  task automatic test_err();
    int w;
    int stalls;
    set_rdy(4'hF);
    send(4'h5, 32'hDEAD_0005, w);
`ifdef TOY_BUS_DEC_ERR_CHK_EN
    tests++;
    if (w != 0 || err_vld !== 1'b1 || o_vld !== 4'b0000) begin
      fails++; $display("FAIL err_first: stall=%0d err_vld=%b out_vld=%b, required 0 1 0000", w, err_vld, o_vld);
    end
    @(posedge clk);
    #1;
    tests++;
    if (err_vld !== 1'b0 || err_cnt !== 8'd1) begin
      fails++; $display("FAIL err_pulse: err_vld=%b err_cnt=%0d, required 0 1", err_vld, err_cnt);
    end
    stalls = 0;
    for (int i = 0; i < 300; i++) begin
      send(4'((i % 12) + 4), 32'(i), w);
      stalls += w;
    end
    @(posedge clk);
    #1;
    tests++;
    if (stalls != 0 || err_cnt !== 8'd255 || o_vld !== 4'b0000) begin
      fails++; $display("FAIL err_saturate: stalls=%0d err_cnt=%0d out_vld=%b, required 0 255 0000", stalls, err_cnt, o_vld);
    end
`else
    stalls = 0;
    tests++;
    if (w != 0 || err_vld !== 1'b0 || o_vld !== 4'b0010) begin
      fails++; $display("FAIL upper_ignored: stall=%0d err_vld=%b out_vld=%b, required 0 0 0010", w, err_vld, o_vld);
    end
    for (int i = 0; i < 8; i++) begin
      send(4'(i + 8), 32'(i), w);
      stalls += w;
    end
    tests++;
    if (stalls != 0 || err_vld !== 1'b0 || err_cnt !== 8'd0) begin
      fails++; $display("FAIL err_tied: stalls=%0d err_vld=%b err_cnt=%0d, required 0 0 0", stalls, err_vld, err_cnt);
    end
`endif
    drain("err");
  endtask

  task automatic test_reset_mid();
    int w;
    set_rdy(4'b1011);
    send(4'h2, 32'h2222_0001, w);
    send(4'h2, 32'h2222_0002, w);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (o_vld !== 4'b0000) begin
      fails++; $display("FAIL midreset_vld: got %b, required 0000", o_vld);
    end
    for (int p = 0; p < 4; p++) exp_q[p].delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_rdy(4'hF);
    send(4'h2, 32'h2222_00F0, w);
    tests++;
    if (o_beat[2] !== {1'b0, 32'h2222_00F0, 4'hD, 4'h2} || o_vld !== 4'b0100) begin
      fails++; $display("FAIL midreset_fresh: got %h vld %b, required %h 0100",
                        o_beat[2], o_vld, {1'b0, 32'h2222_00F0, 4'hD, 4'h2});
    end
    drain("midreset");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hol();
    test_other_port();
    test_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/toy_bus_ack_dec_node.md
Name: toy_bus_ack_dec_node

Overview:
- Decode/split node for the ToyBusAck channel: one upstream ack stream in, four downstream ports out, routed by tgt_id.
- Counterpart of the 4:1 age-matrix ack arbiter node; sits on the return path from the dmem-side merge point to the requesters.
- Each output has a 2-entry FIFO, so outputs are registered and throughput is one beat per cycle per port.

Parameters:
- DATA_W, 32, width of data field
- ID_W, 4, width of src_id/tgt_id
- SEL_LSB, 0, LSB of 2-bit port-select slice in tgt_id (port = tgt_id[SEL_LSB+1:SEL_LSB])
- NODE_BASE, 0, required value of tgt_id[ID_W-1:2] (checked only with optional feature; SEL_LSB must be 0 when enabled)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in0_vld  in  1  upstream ack valid
- in0_rdy  out  1  upstream ack ready
- in0_opcode  in  1  ack opcode
- in0_data  in  DATA_W  ack data
- in0_src_id  in  ID_W  source id
- in0_tgt_id  in  ID_W  target id, used for routing
- outN_vld  out  1  port N valid (N=0..3; FIFO non-empty)
- outN_rdy  in  1  port N ready
- outN_opcode  out  1  port N opcode (FIFO head)
- outN_data  out  DATA_W  port N data
- outN_src_id  out  ID_W  port N src_id
- outN_tgt_id  out  ID_W  port N tgt_id
- err_vld  out  1  illegal-target pulse (tied 0 unless TOY_BUS_DEC_ERR_CHK_EN)
- err_cnt  out  8  saturating illegal-target count (tied 0 unless TOY_BUS_DEC_ERR_CHK_EN)

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - All FIFO counts, read pointers and write pointers = 0; outN_vld = 0.
  - Payload outputs show entry 0, reset to 0.
  - err_vld = 0, err_cnt = 0.
- Routing: sel = in0_tgt_id[SEL_LSB+1:SEL_LSB]; one-hot dec[N] = (sel==N).
- Ready: in0_rdy = ~full[sel], where full = (cnt==2).
  - in0_rdy does not depend on any outN_rdy combinationally.
  - A push into a full FIFO is therefore never possible, even if that FIFO pops in the same cycle.
- Push: in0_vld & in0_rdy writes {opcode,data,src_id,tgt_id} into FIFO[sel] at wptr; wptr toggles.
- Pop: outN_vld & outN_rdy advances rptr[N].
- Count update:
  - push only: cnt+1
  - pop only: cnt-1
  - push and pop on the same FIFO in the same cycle: cnt unchanged (legal at cnt==1 only)
- Latency: a beat accepted in cycle T is presented as outN_vld=1 in T+1. There is no combinational in-to-out path.
- Ordering: strict FIFO order per output port. No ordering guarantee across ports.
- Blocking:
  - A full port stalls the input only while the head input beat targets that port (head-of-line).
  - Other ports keep draining.
- Empty: outN_vld=0; payload holds last head entry (don't-care).
- Protocol:
  - Output payload is stable while outN_vld & ~outN_rdy.
  - Upstream must hold in0_* stable while in0_vld & ~in0_rdy.
- Reset mid-operation: all buffered beats are discarded immediately (asynchronous); nothing replays.

Optional Feature:
- Macro: TOY_BUS_DEC_ERR_CHK_EN.
- Defined:
  - illegal = in0_tgt_id[ID_W-1:2] != NODE_BASE.
  - An illegal beat is accepted with in0_rdy=1 regardless of FIFO state and dropped (no push).
  - err_vld=1 for exactly that accept cycle (registered, visible T+1).
  - err_cnt increments by 1 and saturates at 255.
- Undefined:
  - Upper tgt_id bits are ignored; every beat routes by sel.
  - err_vld and err_cnt are constant 0 and no check logic is built.

Test Plan:
- Reset release, then single beat tgt_id=4'h2, data=32'hA5A5_0001, all outN_rdy=1 -> out2_vld=1 one cycle after accept with matching payload; out0/1/3_vld stay 0.
- Back-to-back beats tgt_id 0,1,2,3,0,... with all outN_rdy=1 -> in0_rdy=1 every cycle; each port sees its beats in order, 1 beat/cycle aggregate.
- out1_rdy=0, three beats to tgt_id=1 -> first two accepted; in0_rdy=0 on third. Raise out1_rdy -> third accepted the cycle after the first pop; order 1st, 2nd, 3rd preserved.
- out3_rdy=0 with FIFO3 full, next beat to tgt_id=0 -> in0_rdy=1, out0 delivers while out3 payload stays stable.
- With TOY_BUS_DEC_ERR_CHK_EN, NODE_BASE=0, beat tgt_id=4'h5 -> in0_rdy=1, no outN_vld, err_vld pulses once, err_cnt=1. 300 illegal beats -> err_cnt=255.
- Assert rst_n low while FIFO2 holds 2 beats -> out2_vld=0 immediately. After release, a new beat to port 2 is delivered with no stale data.
